// File: rtl/store.sv
// store: writes a stream of result elements into a small output RAM. The
// elements are laid out as rows: ROW_LEN elements per row, spaced by a
// column stride, with row starts ROW_PITCH apart. Every address is reduced
// modulo DEPTH, and the host reads the RAM back through a registered port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = reset)
//   start      one-cycle command pulse (acted on only in IDLE)
//   base_addr  first write address
//   stride     column address increment (0 is treated as 1)
//   len        total number of elements to store
//   in_valid   result element valid
//   in_data    result element
//   in_ready   high while a command is accepting data (WRITE)
//   busy       command in progress (WRITE or DONE)
//   done       one-cycle completion pulse
//   wrapped    sticky: some address or row start wrapped past DEPTH-1
//   rd_addr    host readback address
//   rd_data    ram[rd_addr] one cycle later; 0 when rd_addr >= DEPTH
module store #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 18,
  parameter int ROW_LEN   = 3,
  parameter int ROW_PITCH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        base_addr,
  input  logic [1:0]        stride,
  input  logic [4:0]        len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  input  logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [4:0]        row_base;
  logic [4:0]        col;
  logic [4:0]        remaining;
  logic [1:0]        stride_q;
  logic              wrapped_q;
  logic [DATA_W-1:0] rd_data_p1;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [5:0] addr_sum;
  logic [5:0] row_sum;
  logic [5:0] addr_m;
  logic [5:0] row_m;
  logic       xfer;
  logic       last_col;

  // Single conditional subtract of DEPTH on a 6-bit sum. Result is
  // {subtracted, reduced address}. The low five bits of (sum - DEPTH) are
  // exact because the reduced value always fits in five bits.
  function automatic logic [5:0] mod_depth(input logic [5:0] sum);
    logic over;
    over = (sum >= 6'(DEPTH));
    mod_depth = {over, over ? (sum[4:0] - 5'(DEPTH)) : sum[4:0]};
  endfunction

  assign addr_sum = 6'(row_base) + 6'(col) * 6'(stride_q);
  assign row_sum  = 6'(row_base) + 6'(ROW_PITCH);
  assign addr_m   = mod_depth(addr_sum);
  assign row_m    = mod_depth(row_sum);
  assign xfer     = in_valid && (state == WRITE);
  assign last_col = (col == 5'(ROW_LEN - 1));

  assign in_ready = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wrapped  = wrapped_q;
  assign rd_data  = rd_data_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row_base  <= '0;
      col       <= '0;
      remaining <= '0;
      stride_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_base  <= base_addr;
            stride_q  <= (stride == 2'd0) ? 2'd1 : stride;
            remaining <= len;
            col       <= '0;
            wrapped_q <= 1'b0;
            state     <= (len == 5'd0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (xfer) begin
            remaining <= remaining - 5'd1;
            if (last_col) begin
              col      <= '0;
              row_base <= row_m[4:0];
            end else begin
              col <= col + 5'd1;
            end
            // The row-start update only happens at the end of a row, so its
            // wrap only counts then.
            if (addr_m[5] || (last_col && row_m[5])) wrapped_q <= 1'b1;
            if (remaining == 5'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: RAM write and registered readback ----
  // RAM contents survive reset; out-of-range write addresses are dropped.
  always_ff @(posedge clk) begin
    if (xfer && (6'(addr_m[4:0]) < 6'(DEPTH))) mem[addr_m[4:0]] <= in_data;
  end

  // Read-before-write: a same-edge write to rd_addr shows up one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= (6'(rd_addr) < 6'(DEPTH)) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_store.sv
module tb_store;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 18;
  localparam int ROW_LEN   = 3;
  localparam int ROW_PITCH = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        base_addr;
  logic [1:0]        stride;
  logic [4:0]        len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [4:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];

  typedef struct {
    logic [4:0]      base;
    logic [1:0]      stride;
    logic [4:0]      len;
    logic            exp_w;
    logic [0:5][4:0] exp_addr;
  } vec_t;

  vec_t vecs [4];

  store #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ROW_LEN(ROW_LEN), .ROW_PITCH(ROW_PITCH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .stride(stride), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .wrapped(wrapped),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element k of a command: row k/ROW_LEN, column k%ROW_LEN.
  function automatic int model_addr(int b, int s, int k);
    int rb;
    rb = (b + (k / ROW_LEN) * ROW_PITCH) % DEPTH;
    return (rb + (k % ROW_LEN) * s) % DEPTH;
  endfunction

  function automatic bit model_wrap(int b, int s, int n);
    bit w;
    int rb;
    w = 1'b0;
    for (int k = 0; k < n; k++) begin
      rb = (b + (k / ROW_LEN) * ROW_PITCH) % DEPTH;
      if (rb + (k % ROW_LEN) * s >= DEPTH) w = 1'b1;
      if ((k % ROW_LEN) == ROW_LEN - 1 && rb + ROW_PITCH >= DEPTH) w = 1'b1;
    end
    return w;
  endfunction

  task automatic read_check(input string name, input int a, input logic [DATA_W-1:0] exp);
    rd_addr = 5'(a);
    step();
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < DEPTH; a++) read_check({tag, "_ram"}, a, model_mem[a]);
    read_check({tag, "_rd_oob20"}, 20, '0);
    read_check({tag, "_rd_oob31"}, 31, '0);
  endtask

  // Runs one command; element k carries d0+k. gap_pct sets the chance of an
  // idle in_valid cycle, extra_start pulses start mid-command.
  task automatic run_cmd(input logic [4:0] b, input logic [1:0] s, input logic [4:0] n,
                         input logic [DATA_W-1:0] d0, input int gap_pct, input bit extra_start);
    int  sent, cyc, se;
    bit  early_done, exp_w, xfer;
    se    = (s == 2'd0) ? 1 : int'(s);
    exp_w = model_wrap(int'(b), se, int'(n));
    start = 1'b1; base_addr = b; stride = s; len = n; in_valid = 1'b0;
    step();
    start = 1'b0;
    chk("wrapped_clr_on_start", 32'(wrapped), 32'd0);
    chk("in_ready_after_start", 32'(in_ready), 32'(n != 5'd0));
    sent = 0; cyc = 0; early_done = 1'b0;
    while (sent < int'(n) && cyc < 300) begin
      if (done) early_done = 1'b1;
      if (extra_start && cyc == 1) begin
        start = 1'b1; base_addr = ~b; len = 5'd1; stride = 2'd3;
      end else begin
        start = 1'b0;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = DATA_W'(int'(d0) + sent);
      end
      xfer = in_valid && in_ready;
      step();
      if (xfer) begin
        model_mem[model_addr(int'(b), se, sent)] = in_data;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("transfer_budget", 32'(sent), 32'(n));
    chk("no_early_done", 32'(early_done), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("wrapped_flag", 32'(wrapped), 32'(exp_w));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("in_ready_idle", 32'(in_ready), 32'd0);
    chk("wrapped_sticky", 32'(wrapped), 32'(exp_w));
  endtask

  initial begin
    logic [DATA_W-1:0] d0;
    int last;
    int a;

    vecs[0] = '{5'd0,  2'd1, 5'd6, 1'b0, {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8}};
    vecs[1] = '{5'd2,  2'd2, 5'd3, 1'b0, {5'd2, 5'd4, 5'd6, 5'd0, 5'd0, 5'd0}};
    vecs[2] = '{5'd2,  2'd0, 5'd2, 1'b0, {5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0}};
    vecs[3] = '{5'd15, 2'd3, 5'd4, 1'b1, {5'd15, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0}};

    rst = 1'b0; start = 1'b0; base_addr = '0; stride = '0; len = '0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;

    // Reset state
    step(); step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;

    // Fill every RAM entry with known values
    run_cmd(5'd0, 2'd1, 5'd9, 8'h00, 0, 1'b0);
    run_cmd(5'd3, 2'd1, 5'd9, 8'h40, 0, 1'b0);
    check_ram("fill");

    // Directed table
    for (int i = 0; i < 4; i++) begin
      d0 = DATA_W'(10 + 16 * i);
      run_cmd(vecs[i].base, vecs[i].stride, vecs[i].len, d0, 0, 1'b0);
      chk("vec_wrapped", 32'(wrapped), 32'(vecs[i].exp_w));
      for (int j = 0; j < int'(vecs[i].len); j++) begin
        a = int'(vecs[i].exp_addr[j]);
        last = j;
        for (int j2 = j + 1; j2 < int'(vecs[i].len); j2++)
          if (int'(vecs[i].exp_addr[j2]) == a) last = j2;
        read_check("vec_addr_data", a, DATA_W'(int'(d0) + last));
      end
    end
    step(); step();
    chk("wrapped_held_until_start", 32'(wrapped), 32'd1);

    // len=0: one busy/done cycle, RAM untouched
    run_cmd(5'd5, 2'd1, 5'd0, 8'hEE, 0, 1'b0);
    check_ram("len0");

    // Gap-free reference, overwrite, then gapped rerun with a stray start
    run_cmd(5'd4, 2'd1, 5'd7, 8'h30, 0, 1'b0);
    check_ram("nogap");
    run_cmd(5'd4, 2'd1, 5'd7, 8'h70, 0, 1'b0);
    run_cmd(5'd4, 2'd1, 5'd7, 8'h30, 50, 1'b1);
    check_ram("gap_extra_start");

    // Randomized commands against the model
    for (int r = 0; r < 20; r++) begin
      run_cmd(5'($urandom_range(DEPTH - 1)), 2'($urandom_range(3)),
              5'($urandom_range(20)), 8'($urandom), int'($urandom_range(60)),
              1'($urandom_range(1)));
      check_ram("rand");
    end

    // Reset mid-write after two transfers; read-during-write and latency
    start = 1'b1; base_addr = 5'd0; stride = 2'd1; len = 5'd6;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hA0; rd_addr = 5'd0;
    step();
    chk("rd_same_addr_old", 32'(rd_data), 32'(model_mem[0]));
    model_mem[0] = 8'hA0;
    in_data = 8'hA1;
    step();
    chk("rd_latency_1", 32'(rd_data), 32'hA0);
    model_mem[1] = 8'hA1;
    in_data = 8'hA2;
    rst = 1'b0;
    #1;
    chk("rst_abort_in_ready", 32'(in_ready), 32'd0);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_rd_data", 32'(rd_data), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_abort_no_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    start = 1'b1; base_addr = 5'd0; stride = 2'd1; len = 5'd0;
    step();
    start = 1'b0;
    chk("start_first_edge_busy", 32'(busy), 32'd1);
    chk("start_first_edge_done", 32'(done), 32'd1);
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    check_ram("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store.md
STORE -- requirements
Module: store

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the element width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 18, meaning the number of output-RAM entries.
REQ-003 The block SHALL have parameter ROW_LEN, default 3, meaning the elements written per output row.
REQ-004 The block SHALL have parameter ROW_PITCH, default 6, meaning the address distance between row starts.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, on the ports listed below.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle command pulse.
REQ-009 The block SHALL have port base_addr, input, 5 bits: first write address.
REQ-010 The block SHALL have port stride, input, 2 bits: column address increment; the value 0 SHALL be treated as 1.
REQ-011 The block SHALL have port len, input, 5 bits: total number of elements to store.
REQ-012 The block SHALL have port in_valid, input, 1 bit: result element valid.
REQ-013 The block SHALL have port in_data, input, DATA_W bits: result element.
REQ-014 The block SHALL have port in_ready, output, 1 bit: block accepts in_data.
REQ-015 The block SHALL have port busy, output, 1 bit: command in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 The block SHALL have port wrapped, output, 1 bit: sticky flag, set when any address wrapped past DEPTH-1.
REQ-018 The block SHALL have port rd_addr, input, 5 bits: host readback address.
REQ-019 The block SHALL have port rd_data, output, DATA_W bits: registered readback data.

Function
REQ-020 FSM states SHALL be IDLE, WRITE and DONE, and SHALL be held in registered state.
REQ-021 IDLE SHALL act on start=1 as follows: latch base_addr, the effective stride and len; set row_base=base_addr and col=0; go to WRITE, or go to DONE if len=0.
REQ-022 start SHALL be ignored in WRITE and DONE.
REQ-023 in_ready SHALL be 1 only in WRITE; a transfer SHALL occur when in_valid and in_ready are both 1 on a clk edge.
REQ-024 On each transfer, ram[addr] SHALL be set to in_data, where addr = (row_base + col*stride) mod DEPTH.
REQ-025 The modulo SHALL be a single conditional subtract of DEPTH on a 6-bit sum.
REQ-026 The parameters SHALL satisfy (ROW_LEN-1)*3 + DEPTH-1 < 2*DEPTH.
REQ-027 On a transfer with col = ROW_LEN-1: col SHALL become 0 and row_base SHALL become (row_base + ROW_PITCH) mod DEPTH; otherwise col SHALL increment.
REQ-028 wrapped SHALL be set when any addr or row_base computation subtracted DEPTH, and SHALL be cleared only by reset or an accepted start.
REQ-029 A remaining-count SHALL decrement per transfer; the transfer that takes it to 0 SHALL move the FSM to DONE on the same edge.
REQ-030 In DONE, done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-031 busy SHALL be 1 in WRITE and DONE.
REQ-032 A cycle with in_valid=0 in WRITE SHALL change nothing; there SHALL be no timeout.
REQ-033 Write latency SHALL be 1: data accepted on edge N SHALL be readable via rd_addr from edge N+1.
REQ-034 rd_data SHALL equal ram[rd_addr] registered 1 cycle later.
REQ-035 A read and write to the same address on the same edge SHALL return the old data.
REQ-036 rd_addr >= DEPTH SHALL return 0.

Reset
REQ-037 While rst=0, the block SHALL be in IDLE with in_ready=0, busy=0, done=0, wrapped=0, rd_data=0 and all counters 0.
REQ-038 RAM contents SHALL NOT be cleared by reset.
REQ-039 Reset asserted mid-WRITE SHALL abort the command immediately; entries already written SHALL remain, and no done pulse SHALL be produced.
REQ-040 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Verification
REQ-041 The bench SHALL cover this case: base=0, stride=1, len=6, data 10..15 streamed continuously -> ram[0,1,2,6,7,8]=10..15, done one cycle after the last transfer, wrapped=0.
REQ-042 The bench SHALL cover this case: base=2, stride=2, len=3 -> writes land at 2, 4, 6; stride=0 with base=2, len=2 -> writes at 2, 3.
REQ-043 The bench SHALL cover this case: base=15, stride=3, len=4 -> addresses 15, 0, 3 (wrap), then 21 mod 18 = 3 for the next row start; wrapped=1 and stays 1 until the next start.
REQ-044 The bench SHALL cover this case: random in_valid gaps plus start pulsed during WRITE -> same final RAM as the gap-free run; the extra start is ignored.
REQ-045 The bench SHALL cover this case: len=0 -> busy for 1 cycle, done pulse, no RAM change.
REQ-046 The bench SHALL cover this case: rst=0 after 2 of 6 transfers -> in_ready=0 immediately, the 2 entries are retained, the remaining addresses are unchanged, and no done pulse occurs; readback of the same address during a write returns the old value.
